// File: rtl/redundant_to_binary.sv
`default_nettype none
// ============================================================================
//  Module   : redundant_to_binary
//  Purpose  : Resolves a redundant digit vector into canonical binary by
//             rippling the carry DIGITS_PER_CYCLE digits per clock.
//  Revision : 1.0  initial release
// ============================================================================
module redundant_to_binary #(
    parameter int NUM_ELEMENTS     = 66,
    parameter int DSP_BIT_LEN      = 17,
    parameter int WORD_LEN         = 16,
    parameter int DIGITS_PER_CYCLE = 4
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [DSP_BIT_LEN-1:0]              i_dat [NUM_ELEMENTS],
    input  logic                                i_val,
    output logic                                o_rdy,
    output logic [NUM_ELEMENTS*WORD_LEN-1:0]    o_dat,
    output logic [DSP_BIT_LEN-WORD_LEN:0]       o_carry,
    output logic                                o_val,
    input  logic                                i_rdy
);

    localparam int c_carry_len = DSP_BIT_LEN - WORD_LEN + 1;
    localparam int c_chunks    = (NUM_ELEMENTS + DIGITS_PER_CYCLE - 1) / DIGITS_PER_CYCLE;
    localparam int c_pad       = c_chunks * DIGITS_PER_CYCLE;
    localparam int c_idx_w     = (c_chunks > 1) ? $clog2(c_chunks) : 1;
    localparam int c_k_w       = $clog2(c_pad + 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]                         r_state;
    logic [1:0]                         w_next;
    logic [DSP_BIT_LEN-1:0]             r_digit [NUM_ELEMENTS];
    logic [c_carry_len-1:0]             r_carry;
    logic [c_idx_w-1:0]                 r_idx;
    logic [NUM_ELEMENTS*WORD_LEN-1:0]   r_dat;
    logic [c_carry_len-1:0]             r_ocarry;

    logic [DSP_BIT_LEN-1:0]             w_digit_pad [c_pad];
    logic [c_k_w-1:0]                   w_k         [DIGITS_PER_CYCLE];
    logic                               w_ok        [DIGITS_PER_CYCLE];
    logic [DSP_BIT_LEN:0]               w_sum       [DIGITS_PER_CYCLE];
    logic [c_carry_len-1:0]             w_carry     [DIGITS_PER_CYCLE+1];
    logic                               w_accept;
    logic                               w_last;

    // Pad the digit vector to whole chunks so lane reads never leave the array.
    genvar j;
    generate
        for (j = 0; j < c_pad; j++) begin : g_pad
            if (j < NUM_ELEMENTS) begin : g_real
                assign w_digit_pad[j] = r_digit[j];
            end else begin : g_zero
                assign w_digit_pad[j] = '0;
            end
        end
    endgenerate

    // Carry chain across the lanes of one chunk; unused lanes pass it through.
    assign w_carry[0] = r_carry;
    genvar l;
    generate
        for (l = 0; l < DIGITS_PER_CYCLE; l++) begin : g_lane
            assign w_k[l]         = c_k_w'(r_idx) * c_k_w'(DIGITS_PER_CYCLE) + c_k_w'(l);
            assign w_ok[l]        = (w_k[l] < c_k_w'(NUM_ELEMENTS));
            assign w_sum[l]       = {1'b0, w_digit_pad[w_k[l]]} + {{WORD_LEN{1'b0}}, w_carry[l]};
            assign w_carry[l+1]   = w_ok[l] ? w_sum[l][DSP_BIT_LEN:WORD_LEN] : w_carry[l];
        end
    endgenerate

    assign o_rdy    = (r_state == c_st_idle);
    assign o_val    = (r_state == c_st_done);
    assign o_dat    = r_dat;
    assign o_carry  = r_ocarry;
    assign w_accept = o_rdy && i_val;
    assign w_last   = (r_idx == c_idx_w'(c_chunks - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: if (w_accept)          w_next = c_st_run;
            c_st_run:  if (w_last)            w_next = c_st_done;
            c_st_done: if (i_rdy)             w_next = c_st_idle;
            default:                          w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Input digits need no reset: they are only read after a fresh capture.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_digit <= i_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_carry  <= '0;
            r_idx    <= '0;
            r_dat    <= '0;
            r_ocarry <= '0;
        end else if (r_state == c_st_idle) begin
            if (w_accept) begin
                r_carry <= '0;
                r_idx   <= '0;
            end
        end else if (r_state == c_st_run) begin
            r_carry <= w_carry[DIGITS_PER_CYCLE];
            for (int n = 0; n < DIGITS_PER_CYCLE; n++) begin
                if (w_ok[n]) begin
                    r_dat[int'(w_k[n])*WORD_LEN +: WORD_LEN] <= w_sum[n][WORD_LEN-1:0];
                end
            end
            if (w_last) begin
                r_ocarry <= w_carry[DIGITS_PER_CYCLE];
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_redundant_to_binary.sv
`default_nettype none
// ============================================================================
//  Module   : tb_redundant_to_binary
//  Purpose  : Directed-vector and random big-integer checks of the redundant
//             to binary converter, plus backpressure and reset-abort sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_redundant_to_binary;

    localparam int NE   = 66;
    localparam int DL   = 17;
    localparam int WL   = 16;
    localparam int DPC  = 4;
    localparam int CL   = DL - WL + 1;
    localparam int NCH  = (NE + DPC - 1) / DPC;   // 17 chunks
    localparam int OW   = NE * WL;

    typedef struct {
        logic [DL-1:0] dig [NE];
        logic [OW-1:0] exp_dat;
        logic [CL-1:0] exp_carry;
        string         name;
    } vec_t;

    logic            clk;
    logic            rst_n;
    logic [DL-1:0]   tb_dat [NE];
    logic            tb_ival;
    logic            dut_ordy;
    logic [OW-1:0]   dut_odat;
    logic [CL-1:0]   dut_ocarry;
    logic            dut_oval;
    logic            tb_irdy;

    int total;
    int bad;

    vec_t tbl [4];

    redundant_to_binary #(
        .NUM_ELEMENTS     (NE),
        .DSP_BIT_LEN      (DL),
        .WORD_LEN         (WL),
        .DIGITS_PER_CYCLE (DPC)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_dat   (tb_dat),
        .i_val   (tb_ival),
        .o_rdy   (dut_ordy),
        .o_dat   (dut_odat),
        .o_carry (dut_ocarry),
        .o_val   (dut_oval),
        .i_rdy   (tb_irdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic chk_dat(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            for (int k = 0; k < NE; k++) begin
                if (got[k*WL +: WL] !== exp[k*WL +: WL]) begin
                    $display("FAIL %s: word %0d got=%0h required=%0h", name, k,
                             got[k*WL +: WL], exp[k*WL +: WL]);
                    break;
                end
            end
        end
    endtask

    // Big-integer reference: weighted sum of all digits.
    function automatic logic [OW+CL-1:0] ref_sum(input logic [DL-1:0] d [NE]);
        logic [OW+CL-1:0] acc;
        acc = '0;
        for (int k = 0; k < NE; k++) acc = acc + ((OW+CL)'(d[k]) << (WL*k));
        return acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept edge is edge 0; o_val must appear after edge NCH (the 18th edge
    // counting the accept edge itself).
    task automatic run_txn(input logic [DL-1:0] d [NE], input logic [OW-1:0] ed,
                           input logic [CL-1:0] ec, input string name, input bit handshake);
        int lat;
        lat = 0;
        while (!dut_ordy && lat < 50) begin tick(); lat++; end
        chk({name, " rdy_before"}, 64'(dut_ordy), 64'd1);
        tb_dat  = d;
        tb_ival = 1'b1;
        tick();
        tb_ival = 1'b0;
        for (int k = 0; k < NE; k++) tb_dat[k] = '1;
        lat = 0;
        while (!dut_oval && lat < 50) begin tick(); lat++; end
        chk({name, " latency"}, 64'(lat), 64'(NCH));
        chk_dat({name, " o_dat"}, dut_odat, ed);
        chk({name, " o_carry"}, 64'(dut_ocarry), 64'(ec));
        if (handshake) begin
            tick();
            chk({name, " val_drop"}, 64'(dut_oval), 64'd0);
            chk({name, " rdy_back"}, 64'(dut_ordy), 64'd1);
        end
    endtask

    initial begin
        logic [DL-1:0]    d [NE];
        logic [OW+CL-1:0] s;
        logic [OW-1:0]    hold_dat;
        logic [CL-1:0]    hold_carry;

        total = 0;
        bad   = 0;

        // Directed table, expected values worked out by hand.
        for (int k = 0; k < NE; k++) tbl[0].dig[k] = '0;
        tbl[0].exp_dat = '0; tbl[0].exp_carry = 2'd0; tbl[0].name = "zero";

        for (int k = 0; k < NE; k++) tbl[1].dig[k] = '0;
        tbl[1].dig[0] = 17'h1FFFF;
        tbl[1].exp_dat = '0; tbl[1].exp_dat[31:0] = 32'h0001_FFFF;
        tbl[1].exp_carry = 2'd0; tbl[1].name = "d0_max";

        for (int k = 0; k < NE; k++) tbl[2].dig[k] = 17'h0FFFF;
        tbl[2].dig[0] = 17'h10000;
        tbl[2].exp_dat = '0; tbl[2].exp_carry = 2'd1; tbl[2].name = "ripple";

        for (int k = 0; k < NE; k++) tbl[3].dig[k] = 17'h10000;
        tbl[3].exp_dat = '0;
        for (int k = 1; k < NE; k++) tbl[3].exp_dat[k*WL +: WL] = 16'h0001;
        tbl[3].exp_carry = 2'd1; tbl[3].name = "all_10000";

        rst_n   = 1'b0;
        tb_ival = 1'b0;
        tb_irdy = 1'b1;
        for (int k = 0; k < NE; k++) tb_dat[k] = '0;
        tick(); tick();
        rst_n = 1'b1;
        chk("reset o_rdy",   64'(dut_ordy),   64'd1);
        chk("reset o_val",   64'(dut_oval),   64'd0);
        chk_dat("reset o_dat", dut_odat, '0);
        chk("reset o_carry", 64'(dut_ocarry), 64'd0);

        for (int v = 0; v < 4; v++) begin
            run_txn(tbl[v].dig, tbl[v].exp_dat, tbl[v].exp_carry, tbl[v].name, 1'b1);
        end

        for (int it = 0; it < 1000; it++) begin
            for (int k = 0; k < NE; k++) d[k] = DL'($urandom);
            if (it % 10 == 0) for (int k = 0; k < NE; k++) d[k] = (k % 2 == 0) ? 17'h1FFFF : d[k];
            s = ref_sum(d);
            run_txn(d, s[OW-1:0], s[OW +: CL], "random", 1'b1);
        end

        // Backpressure: result must hold while new requests are refused.
        tb_irdy = 1'b0;
        run_txn(tbl[3].dig, tbl[3].exp_dat, tbl[3].exp_carry, "bp", 1'b0);
        hold_dat   = dut_odat;
        hold_carry = dut_ocarry;
        for (int c = 0; c < 10; c++) begin
            tb_ival = c[0];
            for (int k = 0; k < NE; k++) tb_dat[k] = 17'h0ABCD;
            tick();
            chk("bp o_val",   64'(dut_oval),   64'd1);
            chk("bp o_rdy",   64'(dut_ordy),   64'd0);
            chk("bp o_carry", 64'(dut_ocarry), 64'(tbl[3].exp_carry));
            chk_dat("bp o_dat", dut_odat, tbl[3].exp_dat);
        end
        tb_ival = 1'b0;
        tb_irdy = 1'b1;
        tick();
        chk("bp release val", 64'(dut_oval), 64'd0);
        chk("bp release rdy", 64'(dut_ordy), 64'd1);
        tick(); tick();
        chk("bp no_accept rdy", 64'(dut_ordy), 64'd1);
        chk("bp no_accept val", 64'(dut_oval), 64'd0);

        // Reset abort during the 5th RUN cycle.
        for (int k = 0; k < NE; k++) tb_dat[k] = 17'h0FFFF;
        tb_ival = 1'b1;
        tick();
        tb_ival = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort o_rdy",   64'(dut_ordy),   64'd1);
        chk("abort o_val",   64'(dut_oval),   64'd0);
        chk_dat("abort o_dat", dut_odat, '0);
        chk("abort o_carry", 64'(dut_ocarry), 64'd0);
        run_txn(tbl[1].dig, tbl[1].exp_dat, tbl[1].exp_carry, "after_abort", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
